// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller / dispatch sequencer pair.
// Vector byte layout is {2'd0, index[4:0], 1'b0}.
package irq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    RD_LO,
    WAIT_LO,
    RD_HI,
    WAIT_HI,
    DONE
  } irq_dispatch_state_t;

  localparam int IRQ_NMI_BIT   = 0;
  localparam int VEC_INDEX_LSB = 1;
  localparam int VEC_INDEX_W   = 5;

  // Priority of the highest maskable line set; 0 when none is.
  function automatic logic [1:0] level_prio(input logic [3:0] level);
    if (level[3]) return 2'd3;
    if (level[2]) return 2'd2;
    if (level[1]) return 2'd1;
    return 2'd0;
  endfunction

endpackage

// File: rtl/irq_dispatch.sv
// Interrupt dispatch sequencer: qualifies requests against the CPU mask, raises
// them, and on acknowledge fetches the 16-bit handler PC from the vector table.
//
// state   | meaning
// IDLE    | no request presented
// PEND    | request presented to the CPU, waiting for ack
// RD_LO   | bus request for the low vector byte
// WAIT_LO | low byte returning on bus_data_in
// RD_HI   | bus request for the high vector byte
// WAIT_HI | high byte returning on bus_data_in
// DONE    | handler PC strobed to the CPU
module irq_dispatch
  import irq_pkg::*;
#(
  parameter logic [23:0] VECTOR_BASE   = 24'h000000,
  parameter int          GRANT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_level,
  input  logic [7:0]  irq_vector,
  input  logic [1:0]  cpu_mask,
  input  logic        cpu_iack,
  output logic        cpu_irq_req,
  output logic        cpu_nmi_req,
  output logic [1:0]  cpu_irq_prio,
  output logic        cpu_pc_valid,
  output logic [15:0] cpu_handler_pc,
  output logic        cpu_fault,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic        bus_read,
  output logic [23:0] bus_address_out,
  input  logic [7:0]  bus_data_in
);

  localparam logic [7:0] TIMEOUT_LOAD = 8'(GRANT_TIMEOUT);

  irq_dispatch_state_t state;
  logic        nmi_prev;
  logic        nmi_pending;
  logic [7:0]  nmi_vec_q;
  logic [7:0]  vec_q;
  logic [1:0]  prio_q;
  logic [23:0] addr_q;
  logic [7:0]  tmo_cnt;
  logic [15:0] pc;

  logic       nmi_edge;
  logic       nmi_want;
  logic [1:0] lvl_prio;
  logic       mask_qual;
  logic [7:0] nmi_vec;

  // The NMI vector is captured at the edge, since the controller may have moved
  // on to another vector by the time a deferred NMI is serviced.
  assign nmi_edge  = irq_level[IRQ_NMI_BIT] & ~nmi_prev;
  assign nmi_want  = nmi_edge | nmi_pending;
  assign lvl_prio  = level_prio(irq_level);
  assign mask_qual = lvl_prio > cpu_mask;
  assign nmi_vec   = nmi_edge ? irq_vector : nmi_vec_q;

  assign cpu_irq_prio   = prio_q;
  assign cpu_handler_pc = pc;
  assign bus_read       = bus_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      nmi_prev        <= irq_level[IRQ_NMI_BIT];
      nmi_pending     <= 1'b0;
      nmi_vec_q       <= 8'd0;
      vec_q           <= 8'd0;
      prio_q          <= 2'd0;
      addr_q          <= 24'd0;
      tmo_cnt         <= 8'd0;
      pc              <= 16'd0;
      cpu_irq_req     <= 1'b0;
      cpu_nmi_req     <= 1'b0;
      cpu_pc_valid    <= 1'b0;
      cpu_fault       <= 1'b0;
      bus_req         <= 1'b0;
      bus_address_out <= 24'd0;
    end else begin
      nmi_prev <= irq_level[IRQ_NMI_BIT];
      if (nmi_edge) begin
        nmi_pending <= 1'b1;
        nmi_vec_q   <= irq_vector;
      end else if (state == PEND && cpu_iack && cpu_nmi_req) begin
        nmi_pending <= 1'b0;
      end
      if (cpu_iack && state != PEND) cpu_fault <= 1'b1;

      case (state)
        IDLE, PEND: begin
          if (state == PEND && cpu_iack) begin
            state           <= RD_LO;
            cpu_irq_req     <= 1'b0;
            cpu_nmi_req     <= 1'b0;
            prio_q          <= 2'd0;
            addr_q          <= VECTOR_BASE + {16'd0, vec_q};
            bus_req         <= 1'b1;
            bus_address_out <= VECTOR_BASE + {16'd0, vec_q};
            tmo_cnt         <= TIMEOUT_LOAD;
          end else if (nmi_want) begin
            state       <= PEND;
            cpu_nmi_req <= 1'b1;
            cpu_irq_req <= 1'b0;
            prio_q      <= 2'd0;
            vec_q       <= nmi_vec;
          end else if (mask_qual) begin
            state       <= PEND;
            cpu_nmi_req <= 1'b0;
            cpu_irq_req <= 1'b1;
            prio_q      <= lvl_prio;
            vec_q       <= irq_vector;
          end else begin
            state       <= IDLE;
            cpu_nmi_req <= 1'b0;
            cpu_irq_req <= 1'b0;
            prio_q      <= 2'd0;
          end
        end
        RD_LO, RD_HI: begin
          if (bus_grant) begin
            state           <= (state == RD_LO) ? WAIT_LO : WAIT_HI;
            bus_req         <= 1'b0;
            bus_address_out <= 24'd0;
          end else if (tmo_cnt == 8'd0) begin
            state           <= DONE;
            cpu_fault       <= 1'b1;
            bus_req         <= 1'b0;
            bus_address_out <= 24'd0;
            pc              <= 16'd0;
            cpu_pc_valid    <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 8'd1;
          end
        end
        WAIT_LO: begin
          state           <= RD_HI;
          pc[7:0]         <= bus_data_in;
          bus_req         <= 1'b1;
          bus_address_out <= addr_q + 24'd1;
          tmo_cnt         <= TIMEOUT_LOAD;
        end
        WAIT_HI: begin
          state        <= DONE;
          pc[15:8]     <= bus_data_in;
          cpu_pc_valid <= 1'b1;
        end
        DONE: begin
          state        <= IDLE;
          cpu_pc_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
